// File: rtl/hack_alu_pkg.sv
// Shared definitions for the two-stage Hack ALU pipeline.
// Holds the default datapath width and the packed ALU control word.
package hack_alu_pkg;

  localparam int unsigned DefaultWidth = 16;

  // Bit order matches the usual Hack notation "zx nx zy ny f no", MSB first.
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } ctrl_t;

endpackage

// File: rtl/cond_invert16.sv
// Conditional bitwise inverter: passes data through, or its complement when en is set.
module cond_invert16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  output logic [WIDTH-1:0] dout
);

  assign dout = en ? ~din : din;

endmodule

// File: rtl/hack_alu_pipe.sv
// Two-stage valid/ready Hack ALU: S1 registers preset operands, S2 registers result and flags.
// Both stages advance together whenever the output is free or being consumed.
module hack_alu_pipe
  import hack_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  ctrl_t            in_ctrl;
  logic [WIDTH-1:0] x_zeroed, y_zeroed;
  logic [WIDTH-1:0] x_preset, y_preset;

  logic             v1_q;
  logic [WIDTH-1:0] xp_q, yp_q;
  logic             f_q, no_q;

  logic             v2_q;
  logic [WIDTH-1:0] out_q;
  logic             zr_q, ng_q;

  logic             s1_load, s2_load;
  logic [WIDTH-1:0] raw_res, alu_res;

  assign in_ctrl = '{zx: zx, nx: nx, zy: zy, ny: ny, f: f, no: no};

  assign s2_load  = !v2_q || out_ready;
  assign s1_load  = !v1_q || s2_load;
  assign in_ready = s1_load;

  assign x_zeroed = in_ctrl.zx ? '0 : x;
  assign y_zeroed = in_ctrl.zy ? '0 : y;

  cond_invert16 #(.WIDTH(WIDTH)) u_inv_x (
    .din  (x_zeroed),
    .en   (in_ctrl.nx),
    .dout (x_preset)
  );

  cond_invert16 #(.WIDTH(WIDTH)) u_inv_y (
    .din  (y_zeroed),
    .en   (in_ctrl.ny),
    .dout (y_preset)
  );

  // Adder carry is intentionally dropped; the sum wraps modulo 2^WIDTH.
  assign raw_res = f_q ? (xp_q + yp_q) : (xp_q & yp_q);

  cond_invert16 #(.WIDTH(WIDTH)) u_inv_out (
    .din  (raw_res),
    .en   (no_q),
    .dout (alu_res)
  );

  // Data registers only capture on a real beat, so bubbles never pull X into the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q  <= 1'b0;
      xp_q  <= '0;
      yp_q  <= '0;
      f_q   <= 1'b0;
      no_q  <= 1'b0;
      v2_q  <= 1'b0;
      out_q <= '0;
      zr_q  <= 1'b1;
      ng_q  <= 1'b0;
    end else begin
      if (s1_load) begin
        v1_q <= in_valid;
        if (in_valid) begin
          xp_q <= x_preset;
          yp_q <= y_preset;
          f_q  <= in_ctrl.f;
          no_q <= in_ctrl.no;
        end
      end
      if (s2_load) begin
        v2_q <= v1_q;
        if (v1_q) begin
          out_q <= alu_res;
          zr_q  <= (alu_res == '0);
          ng_q  <= alu_res[WIDTH-1];
        end
      end
    end
  end

  assign out_valid = v2_q;
  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Self-checking bench for hack_alu_pipe: directed Hack examples, stall, streaming,
// reset-in-flight and random traffic checked against a transaction-level queue model.
module tb_hack_alu_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [15:0] x, y;
  logic [5:0]  ctrl;
  logic        out_valid, out_ready;
  logic [15:0] out;
  logic        zr, ng;

  hack_alu_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .zx        (ctrl[5]),
    .nx        (ctrl[4]),
    .zy        (ctrl[3]),
    .ny        (ctrl[2]),
    .f         (ctrl[1]),
    .no        (ctrl[0]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    int          vis;
  } ent_t;

  ent_t        q[$];
  logic [15:0] got_q[$];
  int          got_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          known = 0;

  logic        s_valid, s_ready, s_zr, s_ng, s_acc;
  logic [15:0] s_out;

  // Reference Hack ALU, computed with plain integer arithmetic.
  function automatic logic [15:0] hack(input logic [15:0] a, input logic [15:0] b,
                                       input logic [5:0] c);
    int unsigned xa, yb, r;
    xa = c[5] ? 0 : int'(a);
    if (c[4]) xa = 65535 - xa;
    yb = c[3] ? 0 : int'(b);
    if (c[2]) yb = 65535 - yb;
    r = c[1] ? (xa + yb) % 65536 : (xa & yb);
    if (c[0]) r = 65535 - r;
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample and compare at negedge, then advance the model at posedge.
  task automatic step();
    logic        exp_valid, exp_ready, con;
    logic [15:0] hv;
    @(negedge clk);
    exp_valid = known && q.size() > 0 && q[0].vis <= cyc;
    exp_ready = q.size() < 2 || out_ready;
    s_valid = out_valid;
    s_ready = in_ready;
    s_out   = out;
    s_zr    = zr;
    s_ng    = ng;
    if (known) begin
      chk("out_valid", {15'd0, out_valid}, {15'd0, exp_valid});
      chk("in_ready", {15'd0, in_ready}, {15'd0, exp_ready});
      if (exp_valid) begin
        chk("out", out, q[0].val);
        chk("zr", {15'd0, zr}, {15'd0, q[0].val == 16'd0});
        chk("ng", {15'd0, ng}, {15'd0, q[0].val[15]});
      end
    end
    s_acc = in_valid && exp_ready;
    con   = exp_valid && out_ready;
    if (!reset && s_valid && out_ready) begin
      got_q.push_back(s_out);
      got_cyc.push_back(cyc);
    end
    hv = hack(x, y, ctrl);
    @(posedge clk);
    if (reset) begin
      q.delete();
      known = 1;
    end else if (known) begin
      if (con) begin
        void'(q.pop_front());
        if (q.size() > 0 && q[0].vis < cyc + 1) q[0].vis = cyc + 1;
      end
      if (s_acc) q.push_back('{val: hv, vis: cyc + 2});
    end
    cyc++;
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c);
    bit done;
    x = a;
    y = b;
    ctrl = c;
    in_valid = 1'b1;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      step();
      if (s_acc) done = 1;
    end
    if (!done) chk("send_timeout", 16'd0, 16'd1);
    in_valid = 1'b0;
  endtask

  // Single beat with free output: result must appear exactly two cycles after acceptance.
  task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [5:0] c, input logic [15:0] eo, input logic ez,
                        input logic en);
    out_ready = 1'b1;
    send(a, b, c);
    step();
    chk({tag, "_lat1"}, {15'd0, s_valid}, 16'd0);
    step();
    chk({tag, "_valid"}, {15'd0, s_valid}, 16'd1);
    chk({tag, "_out"}, s_out, eo);
    chk({tag, "_zr"}, {15'd0, s_zr}, {15'd0, ez});
    chk({tag, "_ng"}, {15'd0, s_ng}, {15'd0, en});
  endtask

  initial begin
    logic [15:0] av, bv, cv;
    logic [15:0] exp_stream[$];
    logic [15:0] ra, rb;
    logic [5:0]  rc;

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;
    ctrl = '0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_valid", {15'd0, s_valid}, 16'd0);
    chk("rst_out", s_out, 16'd0);
    chk("rst_zr", {15'd0, s_zr}, 16'd1);
    chk("rst_ng", {15'd0, s_ng}, 16'd0);
    chk("rst_ready", {15'd0, s_ready}, 16'd1);

    single("add", 16'd5, 16'd3, 6'b000010, 16'd8, 1'b0, 1'b0);
    single("sub", 16'd5, 16'd3, 6'b010011, 16'd2, 1'b0, 1'b0);
    single("zero", 16'd5, 16'd3, 6'b101010, 16'd0, 1'b1, 1'b0);
    single("minus1", 16'd5, 16'd3, 6'b111010, 16'hFFFF, 1'b0, 1'b1);
    single("wrap", 16'h7FFF, 16'd1, 6'b000010, 16'h8000, 1'b0, 1'b1);
    step();

    // Stall: A and B fill the pipe, C is held off until the output drains.
    got_q.delete();
    out_ready = 1'b0;
    av = hack(16'd10, 16'd20, 6'b000010);
    bv = hack(16'd10, 16'd20, 6'b000000);
    cv = hack(16'd10, 16'd20, 6'b000111);
    send(16'd10, 16'd20, 6'b000010);
    send(16'd10, 16'd20, 6'b000000);
    x = 16'd10;
    y = 16'd20;
    ctrl = 6'b000111;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_ready", {15'd0, s_ready}, 16'd0);
      chk("stall_hold", s_out, av);
    end
    out_ready = 1'b1;
    send(16'd10, 16'd20, 6'b000111);
    for (int i = 0; i < 6; i++) step();
    chk("stall_count", got_q.size(), 16'd3);
    if (got_q.size() == 3) begin
      chk("stall_a", got_q[0], av);
      chk("stall_b", got_q[1], bv);
      chk("stall_c", got_q[2], cv);
    end

    // Streaming: ten back-to-back beats with the output always ready.
    got_q.delete();
    got_cyc.delete();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 6'($urandom);
      x = ra;
      y = rb;
      ctrl = rc;
      exp_stream.push_back(hack(ra, rb, rc));
      step();
      chk("stream_ready", {15'd0, s_ready}, 16'd1);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("stream_count", got_q.size(), 16'd10);
    if (got_q.size() == 10) begin
      chk("stream_span", 16'(got_cyc[9] - got_cyc[0]), 16'd9);
      for (int i = 0; i < 10; i++) chk("stream_val", got_q[i], exp_stream[i]);
    end

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
      x = 16'($urandom);
      y = 16'($urandom);
      ctrl = 6'($urandom);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Reset with two beats in flight; reset wins over a live handshake.
    out_ready = 1'b0;
    send(16'd1, 16'd2, 6'b000010);
    send(16'd3, 16'd4, 6'b000010);
    reset = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    got_q.delete();
    step();
    chk("rif_valid", {15'd0, s_valid}, 16'd0);
    chk("rif_zr", {15'd0, s_zr}, 16'd1);
    chk("rif_ready", {15'd0, s_ready}, 16'd1);
    chk("rif_out", s_out, 16'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("rif_no_stale", got_q.size(), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
